// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the byte-serial 1011 scanner.
// Includes a byte-folding helper used to derive stimulus words.
package seq_scan_pkg;

  localparam int SCAN_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_st_t;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } det_st_t;

  // Folds a 32-bit random value into one stimulus byte.
  function automatic logic [7:0] rand_byte(
    input logic [31:0] seed
  );
    return seed[7:0] ^ seed[15:8]
         ^ seed[23:16] ^ seed[31:24];
  endfunction

endpackage

// File: rtl/seq_detector_1011.sv
// Overlapping 1011 detector, MSB-first serial input.
// match is a one-cycle pulse on the bit completing the pattern.
module seq_detector_1011
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  det_st_t st;
  det_st_t nx;

  always_comb begin
    nx = st;
    unique case (st)
      S0:   nx = bit_in ? S1   : S0;
      S1:   nx = bit_in ? S1   : S10;
      S10:  nx = bit_in ? S101 : S0;
      S101: nx = bit_in ? S1   : S10;
    endcase
  end

  // Combinational so the final bit's match reaches Out on the same edge.
  assign match = en & bit_in & (st == S101);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st <= S0;
    end else if (en) begin
      st <= nx;
    end
  end

endmodule

// File: rtl/top_seq_scan.sv
// Byte-serial scanner: LOAD, WIDTH shift cycles, DONE.
// Out reports whether 1011 occurred in the word; done pulses once.
module top_seq_scan
  import seq_scan_pkg::*;
#(
  parameter int WIDTH = SCAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Input,
  output logic             Out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  scan_st_t         st;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             found;
  logic             match;
  logic             clr;
  logic             en;

  assign clr = (st == ST_LOAD);
  assign en  = (st == ST_SHIFT);

  seq_detector_1011 u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .en     (en),
    .bit_in (shreg[WIDTH-1]),
    .match  (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_LOAD;
      shreg <= '0;
      cnt   <= '0;
      found <= 1'b0;
      Out   <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (st)
        ST_LOAD: begin
          shreg <= Input;
          cnt   <= '0;
          found <= 1'b0;
          done  <= 1'b0;
          st    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          found <= found | match;
          if (cnt == LAST) begin
            Out  <= found | match;
            done <= 1'b1;
            st   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          st   <= ST_LOAD;
        end
        default: begin
          st <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_seq_scan.sv
// Scoreboard bench for top_seq_scan: directed and random words
// checked against a "contains 1011" reference at the fall of done.
module tb_top_seq_scan;
  import seq_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Input = 8'h00;
  logic       Out;
  logic       done;

  int total = 0;
  int bad = 0;
  bit exp_q[$];

  int cyc = 0;
  int last_rise = -1;
  int rises = 0;
  logic prev_done = 1'b0;

  top_seq_scan dut (
    .clk   (clk),
    .rst   (rst),
    .Input (Input),
    .Out   (Out),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic bit has1011(input logic [7:0] w);
    int v;
    v = int'(w);
    for (int s = 0; s <= 4; s++)
      if (((v >> s) & 15) == 11) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: pulse width, pulse spacing, and Out at the fall of done.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_rise = -1;
      prev_done = 1'b0;
    end else begin
      if (done && prev_done)
        check("done_width", 2, 1);
      if (done && !prev_done) begin
        rises++;
        if (last_rise >= 0)
          check("done_period", cyc - last_rise, SCAN_W + 2);
        last_rise = cyc;
      end
      if (!done && prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("out_value", int'(Out), int'(exp_q.pop_front()));
        end
      end
      prev_done = done;
    end
  end

  // Drive one word, wait for its done pulse, then step past DONE.
  task automatic send(input logic [7:0] w);
    int n;
    Input = w;
    exp_q.push_back(has1011(w));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check("latency", n, SCAN_W + 1);
    @(negedge clk);
    Input = 8'h00;
  endtask

  logic [7:0] dir [9] = '{8'hB0, 8'h00, 8'hFF, 8'h0B, 8'h5B,
                          8'hA5, 8'h6D, 8'h24, 8'h0B};

  initial begin
    int r0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", int'(Out), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    foreach (dir[i]) send(dir[i]);

    // Reset in the middle of shifting a matching word.
    r0 = rises;
    Input = 8'hB0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_out", int'(Out), 0);
    check("midrst_done", int'(done), 0);
    rst = 1'b0;
    Input = 8'h2D;
    @(negedge clk);
    check("midrst_no_pulse", rises, r0);
    check("midrst_out_hold", int'(Out), 0);
    Input = 8'h00;
    // Word captured at the first edge after release is 2D.
    begin
      int n;
      exp_q.push_back(has1011(8'h2D));
      n = 1;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("latency_after_rst", n, SCAN_W + 1);
      @(negedge clk);
    end

    for (int i = 0; i < 50; i++)
      send(rand_byte($urandom));

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
